// File: rtl/ahbl_sram_slave.sv
// AHB-Lite slave bridging a 2^AW-byte window onto a single-port synchronous SRAM.
// Writes commit in the final data-phase cycle; a colliding read is deferred one cycle.
module ahbl_sram_slave #(
  parameter int AW          = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic          HREADY,
  input  logic [31:0]   HWDATA,
  output logic [31:0]   HRDATA,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic          SRAM_EN,
  output logic [3:0]    SRAM_WE,
  output logic [AW-3:0] SRAM_A,
  output logic [31:0]   SRAM_DI,
  input  logic [31:0]   SRAM_DO
);

  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

  state_t        state, next_state;
  logic [3:0]    cnt;
  logic [AW-3:0] wa_q;
  logic [3:0]    lanes_q;
  logic          wr_q;
  logic          defer_q;
  logic          cap_q;
  logic [31:0]   hrdata_q;

  logic          size_err;
  logic [3:0]    lanes;
  logic          phase_done;
  logic          take;
  logic          commit;
  logic          rd_now;
  logic          defer_now;
  logic          rd_issue;

  // Address bits above the window and the SEQ/NONSEQ distinction are irrelevant here.
  logic unused_bits;
  assign unused_bits = ^{HADDR[31:AW], HTRANS[0]};

  assign size_err = (HSIZE > 3'd2) ||
                    (HSIZE == 3'd1 && HADDR[0]) ||
                    (HSIZE == 3'd2 && HADDR[1:0] != 2'b00);

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    lanes = 4'b0000;
    case (HSIZE)
      3'd0:    lanes = 4'b0001 << HADDR[1:0];
      3'd1:    lanes = HADDR[1] ? 4'b1100 : 4'b0011;
      3'd2:    lanes = 4'b1111;
      default: lanes = 4'b0000;
    endcase
  end

  // A new address phase may only be taken in a cycle where this slave is ready.
  assign phase_done = (state == IDLE) || (state == ERR2) ||
                      (state == WAIT && cnt == 4'd0);
  assign take       = HSEL && HTRANS[1] && HREADY && phase_done && !HRESET;
  assign commit     = (state == WAIT) && (cnt == 4'd0) && wr_q;
  assign rd_now     = take && !size_err && !HWRITE && !commit;
  assign defer_now  = take && !size_err && !HWRITE && commit;
  assign rd_issue   = rd_now || (state == WAIT && defer_q);

  always_comb begin
    next_state = state;
    HREADYOUT  = 1'b1;
    HRESP      = 1'b0;
    SRAM_EN    = 1'b0;
    SRAM_WE    = 4'b0000;
    SRAM_A     = HADDR[AW-1:2];
    SRAM_DI    = HWDATA;

    case (state)
      IDLE, ERR2: begin
        HREADYOUT = 1'b1;
        HRESP     = (state == ERR2);
        if (take) next_state = size_err ? ERR1 : WAIT;
        else      next_state = IDLE;
      end
      WAIT: begin
        HREADYOUT = (cnt == 4'd0);
        if (cnt == 4'd0) begin
          if (take) next_state = size_err ? ERR1 : WAIT;
          else      next_state = IDLE;
        end
      end
      ERR1: begin
        HREADYOUT  = 1'b0;
        HRESP      = 1'b1;
        next_state = ERR2;
      end
      default: next_state = IDLE;
    endcase

    // The committing write owns the SRAM; reads use it only when it is free.
    if (commit) begin
      SRAM_EN = 1'b1;
      SRAM_WE = lanes_q;
      SRAM_A  = wa_q;
    end else if (state == WAIT && defer_q) begin
      SRAM_EN = 1'b1;
      SRAM_A  = wa_q;
    end else if (rd_now) begin
      SRAM_EN = 1'b1;
    end

    if (HRESET) begin
      SRAM_EN = 1'b0;
      SRAM_WE = 4'b0000;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge HCLK) begin
    if (HRESET) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      cnt      <= 4'd0;
      wa_q     <= '0;
      lanes_q  <= 4'b0000;
      wr_q     <= 1'b0;
      defer_q  <= 1'b0;
      cap_q    <= 1'b0;
      hrdata_q <= 32'h0;
    end else begin
      if (take && !size_err)
        cnt <= defer_now ? 4'(WAIT_STATES + 1) : 4'(WAIT_STATES);
      else if (state == WAIT && cnt != 4'd0)
        cnt <= cnt - 4'd1;

      if (take) begin
        wa_q    <= HADDR[AW-1:2];
        lanes_q <= lanes;
        wr_q    <= HWRITE && !size_err;
      end

      defer_q <= defer_now;
      cap_q   <= rd_issue;
      if (cap_q) hrdata_q <= SRAM_DO;
    end
  end

  assign HRDATA = hrdata_q;

endmodule

// File: tb/tb_ahbl_sram_slave.sv
// Self-checking bench for ahbl_sram_slave: pipelined AHB-Lite master, SRAM model
// and a scoreboard of expected data-phase results.
module tb_ahbl_sram_slave;

  localparam int AW = 12;
  localparam int WS = 1;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic          HREADY;
  logic [31:0]   HWDATA;
  logic [31:0]   HRDATA;
  logic          HREADYOUT;
  logic          HRESP;
  logic          SRAM_EN;
  logic [3:0]    SRAM_WE;
  logic [AW-3:0] SRAM_A;
  logic [31:0]   SRAM_DI;
  logic [31:0]   SRAM_DO;

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  ahbl_sram_slave #(.AW(AW), .WAIT_STATES(WS)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .SRAM_EN(SRAM_EN), .SRAM_WE(SRAM_WE), .SRAM_A(SRAM_A),
    .SRAM_DI(SRAM_DI), .SRAM_DO(SRAM_DO)
  );

  // Synchronous SRAM model: read data valid one cycle after a read strobe.
  logic [31:0] mem [0:(1<<(AW-2))-1];
  int en_count = 0;
  int wr_count = 0;
  always @(posedge HCLK) begin
    if (SRAM_EN) begin
      en_count <= en_count + 1;
      if (|SRAM_WE) begin
        wr_count <= wr_count + 1;
        for (int b = 0; b < 4; b++)
          if (SRAM_WE[b]) mem[SRAM_A][8*b +: 8] <= SRAM_DI[8*b +: 8];
      end else begin
        SRAM_DO <= mem[SRAM_A];
      end
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  typedef struct {
    logic        wr;
    logic        err;
    int          len;
    logic [3:0]  we;
    logic [9:0]  wa;
    logic [31:0] rdata;
  } exp_t;

  xfer_t       seq[$];
  exp_t        sb[$];
  logic [31:0] ref_mem [0:1023];
  int          errors = 0;
  int          checks = 0;

  function automatic logic is_err(input logic [31:0] a, input logic [2:0] s);
    return (s > 3'd2) || (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [3:0] lanes_of(input logic [31:0] a, input logic [2:0] s);
    case (s)
      3'd0:    return 4'b0001 << a[1:0];
      3'd1:    return a[1] ? 4'b1100 : 4'b0011;
      3'd2:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic push_expect(input xfer_t x, input logic deferred);
    exp_t e;
    e.wr  = x.wr;
    e.err = is_err(x.addr, x.size);
    e.we  = lanes_of(x.addr, x.size);
    e.wa  = x.addr[11:2];
    e.len = e.err ? 2 : (WS + 1 + (deferred ? 1 : 0));
    if (!e.err && x.wr)
      for (int b = 0; b < 4; b++)
        if (e.we[b]) ref_mem[e.wa][8*b +: 8] = x.wdata[8*b +: 8];
    e.rdata = ref_mem[e.wa];
    sb.push_back(e);
  endtask

  task automatic drive_addr(input int i);
    if (i < seq.size()) begin
      HSEL   = 1'b1;
      HTRANS = 2'b10;
      HADDR  = seq[i].addr;
      HWRITE = seq[i].wr;
      HSIZE  = seq[i].size;
    end else begin
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      HWRITE = 1'b0;
      HSIZE  = 3'd0;
    end
  endtask

  task automatic add(input logic [31:0] a, input logic w, input logic [2:0] s,
                     input logic [31:0] d);
    xfer_t x;
    x.addr = a; x.wr = w; x.size = s; x.wdata = d;
    seq.push_back(x);
  endtask

  task automatic stop_now(input string why);
    $display("FAIL %s: bound expired", why);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "bench aborted");
  endtask

  // Runs the queued transfers back to back; starts and ends 1 time unit after a rising edge.
  task automatic run_seq(input string name);
    int   ai = 0;
    int   cc = 0;
    int   guard = 0;
    bit   dact = 0;
    bit   ready;
    bit   end_wr;
    exp_t cur;
    drive_addr(0);
    while (dact || ai < seq.size()) begin
      @(negedge HCLK);
      guard++;
      if (guard > 100) stop_now({name, " sequence"});
      ready  = HREADYOUT;
      end_wr = 0;
      if (dact) begin
        cur = sb[0];
        cc++;
        checks++;
        if (HRESP !== cur.err) begin
          errors++;
          $display("FAIL %s hresp: got %b want %b (cycle %0d)", name, HRESP, cur.err, cc);
        end
        if (HREADYOUT) begin
          checks++;
          if (cc != cur.len) begin
            errors++;
            $display("FAIL %s phase_len: got %0d want %0d", name, cc, cur.len);
          end
          if (!cur.err && cur.wr) begin
            end_wr = 1;
            checks++;
            if ({SRAM_EN, SRAM_WE, SRAM_A} !== {1'b1, cur.we, cur.wa}) begin
              errors++;
              $display("FAIL %s commit: got en=%b we=%b a=%h want en=1 we=%b a=%h",
                       name, SRAM_EN, SRAM_WE, SRAM_A, cur.we, cur.wa);
            end
          end else if (!cur.err) begin
            checks++;
            if (HRDATA !== cur.rdata) begin
              errors++;
              $display("FAIL %s hrdata: got %h want %h", name, HRDATA, cur.rdata);
            end
          end
          void'(sb.pop_front());
          dact = 0;
        end else if (cur.wr) begin
          checks++;
          if (SRAM_WE !== 4'b0000) begin
            errors++;
            $display("FAIL %s early_we: got %b want 0000", name, SRAM_WE);
          end
        end
      end
      @(posedge HCLK);
      if (ready && ai < seq.size()) begin
        push_expect(seq[ai], end_wr && !seq[ai].wr && !is_err(seq[ai].addr, seq[ai].size));
        ai++;
        dact = 1;
        cc = 0;
      end
      #1;
      drive_addr(ai);
      HWDATA = (dact && ai > 0) ? seq[ai-1].wdata : 32'h0;
    end
    seq.delete();
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h4; HWRITE = 1'b0; HSIZE = 3'd2;
    HWDATA = 32'h0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    checks++;
    if ({SRAM_EN, SRAM_WE} !== 5'b0) begin
      errors++;
      $display("FAIL reset_sram_gate: got en=%b we=%b want 0/0000", SRAM_EN, SRAM_WE);
    end
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    HSEL = 1'b0; HTRANS = 2'b00;
    @(negedge HCLK);
    checks++;
    if ({HREADYOUT, HRESP, HRDATA} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b resp=%b rdata=%h want 1/0/00000000",
               HREADYOUT, HRESP, HRDATA);
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_idle_busy();
    logic [2:0] pat [3];
    pat[0] = 3'b1_00;  // selected IDLE
    pat[1] = 3'b1_01;  // selected BUSY
    pat[2] = 3'b0_10;  // unselected NONSEQ
    for (int i = 0; i < 3; i++) begin
      HSEL = pat[i][2]; HTRANS = pat[i][1:0]; HADDR = 32'h8; HWRITE = 1'b0; HSIZE = 3'd2;
      @(negedge HCLK);
      checks++;
      if ({HREADYOUT, HRESP, SRAM_EN} !== 3'b100) begin
        errors++;
        $display("FAIL idle_busy[%0d]: got rdy=%b resp=%b en=%b want 1/0/0",
                 i, HREADYOUT, HRESP, SRAM_EN);
      end
      @(posedge HCLK);
      #1;
    end
    HSEL = 1'b0; HTRANS = 2'b00;
  endtask

  task automatic test_word_write_read();
    add(32'h004, 1'b1, 3'd2, 32'hCAFEF00D);
    run_seq("word_write");
    add(32'h004, 1'b0, 3'd2, 32'h0);
    run_seq("word_read");
  endtask

  task automatic test_byte_lanes();
    add(32'h007, 1'b1, 3'd0, 32'hAB000000);
    run_seq("byte_write");
    add(32'h004, 1'b0, 3'd2, 32'h0);
    run_seq("byte_read");
    add(32'h00E, 1'b1, 3'd1, 32'h5A5A0000);
    run_seq("half_write");
    add(32'h00C, 1'b1, 3'd2, 32'h11223344);
    add(32'h00E, 1'b1, 3'd1, 32'hBEEF0000);
    add(32'h00D, 1'b1, 3'd0, 32'h00007700);
    run_seq("lane_mix");
    add(32'h00C, 1'b0, 3'd2, 32'h0);
    run_seq("lane_read");
  endtask

  task automatic test_back_to_back();
    add(32'h008, 1'b1, 3'd2, 32'h12345678);
    add(32'h008, 1'b0, 3'd2, 32'h0);
    add(32'h004, 1'b0, 3'd2, 32'h0);
    add(32'h00C, 1'b1, 3'd2, 32'h0BADF00D);
    add(32'h00C, 1'b0, 3'd2, 32'h0);
    run_seq("back_to_back");
  endtask

  task automatic test_error();
    int c0 = en_count;
    add(32'h001, 1'b0, 3'd1, 32'h0);
    add(32'h000, 1'b0, 3'd3, 32'h0);
    add(32'h002, 1'b1, 3'd2, 32'hFFFFFFFF);
    run_seq("error");
    checks++;
    if (en_count != c0) begin
      errors++;
      $display("FAIL error_no_sram: got %0d strobes want 0", en_count - c0);
    end
    add(32'h004, 1'b0, 3'd2, 32'h0);
    run_seq("after_error_read");
  endtask

  task automatic test_reset_mid_write();
    int w0;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h008; HWRITE = 1'b1; HSIZE = 3'd2;
    @(posedge HCLK);
    #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    HWDATA = 32'hDEADBEEF;
    HRESET = 1'b1;
    w0 = wr_count;
    @(negedge HCLK);
    checks++;
    if ({SRAM_EN, SRAM_WE} !== 5'b0) begin
      errors++;
      $display("FAIL rst_mid_gate: got en=%b we=%b want 0/0000", SRAM_EN, SRAM_WE);
    end
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    checks++;
    if ({HREADYOUT, HRESP, SRAM_EN} !== 3'b100) begin
      errors++;
      $display("FAIL rst_mid_state: got rdy=%b resp=%b en=%b want 1/0/0",
               HREADYOUT, HRESP, SRAM_EN);
    end
    @(posedge HCLK);
    #1;
    checks++;
    if (wr_count != w0) begin
      errors++;
      $display("FAIL rst_mid_nowrite: got %0d writes want 0", wr_count - w0);
    end
    add(32'h008, 1'b0, 3'd2, 32'h0);
    run_seq("rst_mid_read");
  endtask

  task automatic test_alias();
    add(32'h1004, 1'b0, 3'd2, 32'h0);
    add(32'hFFFFF00C, 1'b0, 3'd2, 32'h0);
    run_seq("alias");
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    test_reset();
    test_idle_busy();
    test_word_write_read();
    test_byte_lanes();
    test_back_to_back();
    test_error();
    test_reset_mid_write();
    test_alias();
    repeat (2) @(posedge HCLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    stop_now("watchdog");
  end

endmodule
